// File: rtl/rotatix_pkg.sv
// rotatix shared types: quadrature Gray-code states, direction codes, defaults.
// Detent (x1) decoding is selected with `define ROTATIX_DETENT_DIV_EN.
package rotatix_pkg;

    typedef enum logic [1:0] {
        Q_00 = 2'b00,
        Q_01 = 2'b01,
        Q_11 = 2'b11,
        Q_10 = 2'b10
    } quad_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    localparam int DEB_CYC_DEFAULT = 4;

    // Clockwise successor in the 00->01->11->10 ring
    function automatic quad_t cw_next(input quad_t s);
        quad_t n;
        n = Q_01;
        unique case (s)
            Q_00: n = Q_01;
            Q_01: n = Q_11;
            Q_11: n = Q_10;
            Q_10: n = Q_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rotatix_debounce.sv
// One-bit input conditioner: 2-flop synchronizer followed by a
// consecutive-sample debouncer holding level q.
module rotatix_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam logic [7:0] LAST = 8'(DEB_CYC - 1);

    logic       s1_q;
    logic       s2_q;
    logic       lvl_q;
    logic       lvl_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == LAST) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= d;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign q = lvl_q;

endmodule

// File: rtl/rotatix_quad_decoder.sv
// rotatix front end: conditioned A/B/button pins, quadrature decode, counter.
// `define ROTATIX_DETENT_DIV_EN for one count per detent instead of x4.
module rotatix_quad_decoder
    import rotatix_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_btn,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             btn_press,
    output logic             err
);

    logic a_deb;
    logic b_deb;
    logic btn_deb;

    rotatix_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .d(enc_a), .q(a_deb)
    );
    rotatix_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .d(enc_b), .q(b_deb)
    );
    rotatix_debounce #(.DEB_CYC(DEB_CYC)) u_deb_btn (
        .clk(clk), .rst_n(rst_n), .d(enc_btn), .q(btn_deb)
    );

    quad_t            st_q;
    quad_t            ab;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             btn_q, btn_d;
    logic             err_q, err_d;
    logic             btn_prev_q;
    logic             moved, illegal, cw, ccw, up, dn;

    assign ab      = quad_t'({a_deb, b_deb});
    assign moved   = (ab != st_q);
    assign illegal = ((ab ^ st_q) == 2'b11);
    assign cw      = moved && (ab == cw_next(st_q));
    assign ccw     = moved && (st_q == cw_next(ab));

`ifdef ROTATIX_DETENT_DIV_EN
    // Only the edge that lands back on 00 counts a full detent
    assign up = cw && (ab == Q_00);
    assign dn = ccw && (ab == Q_00);
`else
    assign up = cw;
    assign dn = ccw;
`endif

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        btn_d   = 1'b0;
        err_d   = err_q;
        if (ena) begin
            if (up || dn) begin
                count_d = up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                dir_d   = up ? DIR_CW : DIR_CCW;
                step_d  = 1'b1;
            end
            if (illegal) begin
                err_d = 1'b1;
            end
            btn_d = btn_deb && !btn_prev_q;
        end
        if (clr) begin
            count_d = '0;
            err_d   = 1'b0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= Q_00;
            count_q    <= '0;
            dir_q      <= DIR_CCW;
            step_q     <= 1'b0;
            btn_q      <= 1'b0;
            err_q      <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            st_q       <= ab;
            count_q    <= count_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            btn_q      <= btn_d;
            err_q      <= err_d;
            btn_prev_q <= btn_deb;
        end
    end

    assign count     = count_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign btn_press = btn_q;
    assign err       = err_q;

endmodule
